// File: rtl/fifo_stream_reader_pkg.sv
// rtl/fifo_stream_reader_pkg.sv - shared limits and helpers for the FIFO stream reader
package fifo_stream_reader_pkg;

  localparam int MAX_READ_LATENCY = 3;

  function automatic bit params_legal(input int read_latency, input int buf_depth);
    return (read_latency >= 0) && (read_latency <= MAX_READ_LATENCY) &&
           (buf_depth >= read_latency + 1);
  endfunction

  function automatic int wrap_inc(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - flop-based circular queue with push/pop, count and valid
// Popping while empty is ignored; the caller guarantees push never hits a full queue.
module stream_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [CW-1:0]         count;
  logic                  do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign data   = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_idx <= IW'(wrap_inc(int'(wr_idx), DEPTH));
      end
      if (do_pop) begin
        rd_idx <= IW'(wrap_inc(int'(rd_idx), DEPTH));
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains an upstream sync FIFO into a valid/ready stream
// Credits bound popped-but-unaccepted words, so the output buffer can never overflow.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = READ_LATENCY + 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]          fifo_data_i,
  output logic                           fifo_pop_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0] inflight_o
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  if (!params_legal(READ_LATENCY, BUF_DEPTH)) begin : g_bad_params
    $error("fifo_stream_reader: READ_LATENCY must be 0..%0d and BUF_DEPTH >= READ_LATENCY+1",
           MAX_READ_LATENCY);
  end

  logic [CW-1:0] inflight;
  logic          has_credit;
  logic          accept;
  logic          land;

  assign has_credit = (inflight != CW'(BUF_DEPTH));
  assign accept     = m_valid_o & m_ready_i;
  assign fifo_pop_o = en_i & ~fifo_empty_i & has_credit & ~rst_i;
  assign inflight_o = inflight;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= '0;
    end else begin
      case ({fifo_pop_o, accept})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Tag pipe mirrors the FIFO read latency so data lands exactly when it is valid.
  if (READ_LATENCY == 0) begin : g_show_ahead
    assign land = fifo_pop_o;
  end else begin : g_tag_pipe
    logic [READ_LATENCY-1:0] vpipe;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vpipe <= '0;
      end else begin
        vpipe[0] <= fifo_pop_o;
        for (int i = 1; i < READ_LATENCY; i++) begin
          vpipe[i] <= vpipe[i-1];
        end
      end
    end

    assign land = vpipe[READ_LATENCY-1];
  end

  stream_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (land),
    .push_data(fifo_data_i),
    .pop      (m_ready_i),
    .data     (m_data_o),
    .valid    (m_valid_o)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - bench for fifo_stream_reader at read latencies 1, 0 and 3
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int N  = 3;

  function automatic int rl_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic int bd_of(input int k);
    return rl_of(k) + 2;
  endfunction

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic          ready = 1'b0;
  logic [N-1:0]  pop;
  logic [N-1:0]  valid;
  logic [N-1:0]  fempty;
  logic [DW-1:0] fdata [N];
  logic [DW-1:0] mdata [N];
  logic [2:0]    infl  [N];

  logic [DW-1:0] src [0:255];
  logic [7:0]    src_n = '0;
  logic [7:0]    frd [N];
  logic [DW-1:0] dp [N][4];

  logic [7:0]    exp_idx [N];
  int            pops [N];
  int            beats [N];
  int            max_infl [N];
  int            pop_cyc [N][256];
  int            beat_cyc [N][256];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int RL = rl_of(k);
    logic [$clog2(RL+3)-1:0] infl_k;

    fifo_stream_reader #(
      .DATA_WIDTH  (DW),
      .READ_LATENCY(RL)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .en_i        (en),
      .fifo_empty_i(fempty[k]),
      .fifo_data_i (fdata[k]),
      .fifo_pop_o  (pop[k]),
      .m_valid_o   (valid[k]),
      .m_ready_i   (ready),
      .m_data_o    (mdata[k]),
      .inflight_o  (infl_k)
    );

    assign infl[k] = 3'(infl_k);

    if (RL == 0) begin : g_sa
      assign fdata[k] = src[frd[k]];
    end else begin : g_lat
      assign fdata[k] = dp[k][RL-1];
    end
  end

  // Upstream FIFO model: registered empty flag, data valid RL cycles after pop.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        frd[k]    <= src_n;
        fempty[k] <= 1'b1;
      end else begin
        frd[k]    <= frd[k] + 8'(pop[k]);
        fempty[k] <= (src_n == frd[k] + 8'(pop[k]));
        dp[k][0]  <= pop[k] ? src[frd[k]] : (32'hBAD0_0000 | 32'(k));
        for (int j = 1; j < 4; j++) dp[k][j] <= dp[k][j-1];
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst=%0d got=%h required=%h t=%0t", name, k, act, req, $time);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < N; k++) begin
      if (pop[k]) begin
        check("pop_when_empty", k, 32'(fempty[k]), 32'd0);
        pop_cyc[k][pops[k]] = cyc;
        pops[k]++;
      end
      if (int'(infl[k]) > max_infl[k]) max_infl[k] = int'(infl[k]);
      if (valid[k] && ready) begin
        beat_cyc[k][beats[k]] = cyc;
        beats[k]++;
        if (exp_idx[k] == src_n) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat inst=%0d got=%h required=no beat t=%0t", k, mdata[k], $time);
        end else begin
          check("data_order", k, mdata[k], src[exp_idx[k]]);
          exp_idx[k]++;
        end
      end
    end
  endtask

  task automatic half_b();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    half_b();
  endtask

  task automatic push(input logic [31:0] v);
    src[src_n] = v;
    src_n++;
  endtask

  task automatic drain(input string tag);
    bit done;
    for (int i = 0; i < 200; i++) begin
      done = 1'b1;
      for (int k = 0; k < N; k++) if (exp_idx[k] != src_n || infl[k] != 3'd0) done = 1'b0;
      if (done) break;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      check({tag, "_delivered"}, k, 32'(exp_idx[k]), 32'(src_n));
      check({tag, "_inflight"}, k, 32'(infl[k]), 32'd0);
    end
  endtask

  typedef struct {
    logic rdy;
    logic e_pop;
    logic e_val;
    int   e_inf;
    int   e_word;
  } vec_t;

  vec_t tbl [11];
  int   p0 [N];
  int   b0 [N];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0, -1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, -1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, -1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 2, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 3, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 3, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 3, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2, 2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 3, 3};
    for (int k = 0; k < N; k++) begin
      exp_idx[k] = '0; pops[k] = 0; beats[k] = 0; max_infl[k] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check("rst_pop", k, 32'(pop[k]), 32'd0);
      check("rst_valid", k, 32'(valid[k]), 32'd0);
      check("rst_inflight", k, 32'(infl[k]), 32'd0);
    end
    rst = 1'b0;

    // Stalled sink with 10 words queued, then a few accepts (checked on the latency-1 instance)
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    en = 1'b1;
    for (int r = 0; r < 11; r++) begin
      ready = tbl[r].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_pop", r), 0, 32'(pop[0]), 32'(tbl[r].e_pop));
      check($sformatf("tbl%0d_valid", r), 0, 32'(valid[0]), 32'(tbl[r].e_val));
      check($sformatf("tbl%0d_inflight", r), 0, 32'(infl[0]), 32'(tbl[r].e_inf));
      if (tbl[r].e_word >= 0)
        check($sformatf("tbl%0d_data", r), 0, mdata[0], 32'h100 + 32'(tbl[r].e_word));
      half_b();
    end
    ready = 1'b1;
    drain("stall");

    // Preloaded 0x01..0x08 with sink always ready: latency and back-to-back beats
    for (int k = 0; k < N; k++) begin p0[k] = pops[k]; b0[k] = beats[k]; end
    for (int i = 1; i <= 8; i++) push(32'(i));
    drain("burst");
    for (int k = 0; k < N; k++) begin
      check("burst_pops", k, 32'(pops[k] - p0[k]), 32'd8);
      check("burst_beats", k, 32'(beats[k] - b0[k]), 32'd8);
      check("burst_latency", k, 32'(beat_cyc[k][b0[k]] - pop_cyc[k][p0[k]]), 32'(rl_of(k) + 1));
      check("burst_span", k, 32'(beat_cyc[k][b0[k] + 7] - beat_cyc[k][b0[k]]), 32'd7);
    end

    // Sink ready toggling every cycle, 16 words
    for (int k = 0; k < N; k++) b0[k] = beats[k];
    for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
    for (int i = 0; i < 100; i++) begin
      ready = ~ready;
      tick();
      if (exp_idx[0] == src_n && exp_idx[1] == src_n && exp_idx[2] == src_n) break;
    end
    ready = 1'b1;
    drain("toggle");
    for (int k = 0; k < N; k++) begin
      check("toggle_beats", k, 32'(beats[k] - b0[k]), 32'd16);
      check("max_inflight", k, 32'(max_infl[k] <= bd_of(k)), 32'd1);
    end

    // Single word: one pop, one beat
    for (int k = 0; k < N; k++) begin p0[k] = pops[k]; b0[k] = beats[k]; end
    push(32'hA5A5_0001);
    repeat (12) tick();
    for (int k = 0; k < N; k++) begin
      check("single_pops", k, 32'(pops[k] - p0[k]), 32'd1);
      check("single_beats", k, 32'(beats[k] - b0[k]), 32'd1);
      check("single_inflight", k, 32'(infl[k]), 32'd0);
    end

    // Reset mid-stream once the latency-1 instance holds two words in flight
    ready = 1'b0;
    for (int i = 0; i < 10; i++) push(32'h300 + 32'(i));
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (infl[0] == 3'd2) begin
          found = 1'b1;
          break;
        end
        half_b();
      end
      check("reach_inflight2", 0, 32'(found), 32'd1);
    end
    #2;
    rst = 1'b1;
    for (int k = 0; k < N; k++) exp_idx[k] = src_n;
    #1;
    for (int k = 0; k < N; k++) begin
      check("async_valid", k, 32'(valid[k]), 32'd0);
      check("async_inflight", k, 32'(infl[k]), 32'd0);
      check("async_pop", k, 32'(pop[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) p0[k] = pops[k];
    repeat (5) tick();
    for (int k = 0; k < N; k++) check("post_rst_no_pop", k, 32'(pops[k] - p0[k]), 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i));
    drain("post_rst");
    for (int k = 0; k < N; k++) check("post_rst_pops", k, 32'(pops[k] - p0[k]), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO words and stream data.
REQ-002 Parameter READ_LATENCY, default 1, legal 0..3; 0 = show-ahead FIFO data, N>=1 = fifo_data_i valid N cycles after pop.
REQ-003 Parameter BUF_DEPTH, default READ_LATENCY+2, output buffer entries; minimum READ_LATENCY+1.
REQ-004 clk_i  input  1  single clock, rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 en_i  input  1  drain enable; 0 stops new pops, in-flight words still land.
REQ-007 fifo_empty_i  input  1  upstream sync FIFO empty flag, registered at source.
REQ-008 fifo_data_i  input  DATA_WIDTH  upstream FIFO read data.
REQ-009 fifo_pop_o  output  1  pop strobe to upstream FIFO.
REQ-010 m_valid_o  output  1  stream data valid.
REQ-011 m_ready_i  input  1  stream sink ready.
REQ-012 m_data_o  output  DATA_WIDTH  stream data.
REQ-013 inflight_o  output  $clog2(BUF_DEPTH+1)  words popped but not yet accepted downstream.

Function
REQ-014 fifo_pop_o SHALL equal en_i & ~fifo_empty_i & (credit > 0) & ~rst_i, combinational; credit = BUF_DEPTH - inflight.
REQ-015 inflight SHALL increment on pop without accept, decrement on accept (m_valid_o & m_ready_i) without pop, hold otherwise; never exceeds BUF_DEPTH, never underflows.
REQ-016 READ_LATENCY=0: fifo_data_i SHALL be written into the buffer in the pop cycle.
REQ-017 READ_LATENCY=N>=1: a valid shift register of N stages SHALL track pops; fifo_data_i SHALL be written into the buffer in the cycle the pop's tag exits stage N.
REQ-018 Buffer SHALL be a circular queue of BUF_DEPTH entries with wrapping write/read indices; write and read in the same cycle SHALL both take effect.
REQ-019 m_valid_o SHALL be 1 whenever the buffer holds >= 1 word; m_data_o SHALL be the oldest buffered word, registered, stable while m_valid_o & ~m_ready_i.
REQ-020 Words SHALL emerge in pop order; no loss or duplication under any m_ready_i pattern.
REQ-021 Latency first pop to m_valid_o: READ_LATENCY+1 cycles.
REQ-022 With default BUF_DEPTH and m_ready_i held 1 on a non-empty FIFO, throughput SHALL be 1 word/cycle after initial latency.
REQ-023 Last-word case: pop when the FIFO holds one word; fifo_empty_i rises next cycle, no second pop issued (source empty is registered post-pop).
REQ-024 Buffer full (inflight = BUF_DEPTH): fifo_pop_o SHALL be 0 until an accept frees a credit; pop and accept in the same cycle are legal.
REQ-025 en_i falling SHALL not cancel in-flight pops; those words SHALL still be delivered.

Reset
REQ-026 rst_i assertion SHALL asynchronously clear inflight, buffer indices, buffer count, and latency valid pipe; m_valid_o=0, inflight_o=0, fifo_pop_o=0.
REQ-027 Buffer data storage SHALL not be reset.
REQ-028 Reset mid-operation SHALL discard in-flight and buffered words; the upstream FIFO is reset by the same rst_i.
REQ-029 First pop SHALL occur no earlier than the first rising edge after rst_i deasserts.

Structure
REQ-030 No package types required; BUF_DEPTH/READ_LATENCY legality SHALL be checked by an elaboration-time assertion.
REQ-031 One sub-module, stream_buf: flop-based circular queue with push/pop/count/valid, parameterised by DATA_WIDTH and BUF_DEPTH.

Verification
REQ-032 READ_LATENCY=1, FIFO preloaded 0x01..0x08, m_ready_i=1, en_i=1 -> m_data_o 0x01..0x08 on 8 consecutive cycles, first at cycle 2 after first pop.
REQ-033 m_ready_i=0 with 10 words queued, BUF_DEPTH=3 -> exactly 3 pops, inflight_o=3, fifo_pop_o=0 thereafter, m_data_o=first word held.
REQ-034 m_ready_i toggling 1/0 every cycle, 16 words -> all 16 delivered in order, no duplicates, inflight_o never >3.
REQ-035 Single word in FIFO -> exactly one fifo_pop_o pulse, one m_valid_o beat, inflight_o returns to 0.
REQ-036 rst_i asserted mid-stream with inflight_o=2 -> m_valid_o and inflight_o 0 immediately (no clock edge), no further pops until data re-pushed after reset release.
REQ-037 READ_LATENCY=0 and 3 each: REQ-032 stimulus -> identical ordered output, first beat at cycle READ_LATENCY+1.
